gpio_hex_display: RTL

GPIO_HEX_DISPLAY -- requirements
Module: gpio_hex_display

---
 rtl/gpio_hex_display.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gpio_hex_display.sv
// gpio_hex_display
// Buffers processor GPIO writes in a small FIFO and shows each value on eight
// seven-segment digits for at least HOLD_CYCLES+1 clock cycles before moving
// on to the next buffered value. Writes arriving while the FIFO is full (and
// nothing is being popped) are dropped and flagged on the sticky overflow bit.
//
// Optional build macro:
//   GPIO_HEX_LZ_BLANK_EN - blank leading-zero digits hex7..hex1 (hex0 always lit).
//   Undefined by default: every digit always shows its glyph.

module gpio_hex_display #(
    parameter int FIFO_DEPTH  = 4,   // pending-write entries, power of two, >= 2
    parameter int HOLD_CYCLES = 16   // minimum display time per value, >= 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we_gpio,
    input  logic [31:0]                   gpio_data,
    output logic [6:0]                    hex0,
    output logic [6:0]                    hex1,
    output logic [6:0]                    hex2,
    output logic [6:0]                    hex3,
    output logic [6:0]                    hex4,
    output logic [6:0]                    hex5,
    output logic [6:0]                    hex6,
    output logic [6:0]                    hex7,
    output logic [31:0]                   shown_value,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          overflow
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

    // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] hold_cnt;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          drop;

    logic [6:0]    hex_seg [8];

    // ------------------------------------------------------------------
    // FIFO handshake
    // ------------------------------------------------------------------
    // The only consumer is the LOAD state, which is entered solely when the
    // FIFO holds at least one entry, so a pop never underflows.
    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign fifo_empty = (fifo_level == '0);
    assign pop        = (state == LOAD);
    // A full FIFO can still accept a write when the head leaves on the same edge.
    assign push       = we_gpio && (!fifo_full || pop);
    assign drop       = we_gpio && fifo_full && !pop;

    // Pointer, level and overflow bookkeeping.
    // NOTE: registers update with non-blocking assignments so every always_ff
    // sees the pre-edge values of the others, regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            // Power-of-two depth makes the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase

            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and level, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= gpio_data;
    end

    // ------------------------------------------------------------------
    // Display sequencer: IDLE -> LOAD -> HOLD -> (LOAD | IDLE)
    // ------------------------------------------------------------------
    // Sequencer FSM with registered display value and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            shown_value <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    shown_value <= fifo_mem[rd_ptr];
                    hold_cnt    <= HOLD_RELOAD;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= fifo_empty ? IDLE : LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy whenever a value is being sequenced or anything is still queued.
    assign busy = (state != IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Seven-segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] seg;
        unique case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

`ifdef GPIO_HEX_LZ_BLANK_EN
    // Glyph decode with leading-zero suppression on hex7..hex1.
    always_comb begin
        logic zero_above;
        // NOTE: every combinational output gets a value before any condition
        // can skip it; otherwise synthesis infers a latch to hold it.
        for (int i = 0; i < 8; i++) begin
            hex_seg[i] = hex_glyph(shown_value[4*i +: 4]);
        end
        // Walk from the top digit down; a digit blanks only while it and
        // every digit above it are zero. hex0 is outside the walk.
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above = zero_above && (shown_value[4*i +: 4] == 4'h0);
            if (zero_above) hex_seg[i] = SEG_BLANK;
        end
    end
`else
    // Plain glyph decode of all eight nibbles.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hex_seg[i] = hex_glyph(shown_value[4*i +: 4]);
        end
    end
`endif

    assign hex0 = hex_seg[0];
    assign hex1 = hex_seg[1];
    assign hex2 = hex_seg[2];
    assign hex3 = hex_seg[3];
    assign hex4 = hex_seg[4];
    assign hex5 = hex_seg[5];
    assign hex6 = hex_seg[6];
    assign hex7 = hex_seg[7];

endmodule
